axonerve_kvs_cmd_issuer: RTL and testbench
==========================================

# axonerve_kvs_cmd_issuer

Command issuer that sits directly upstream of `axonerve_kvs_kernel`. It accepts packed KVS requests over a valid/ready stream and drives the kernel's one-hot `I_CMD_*` command interface. Each command is issued only when the kernel reports ready, not waiting and not full, and only within an outstanding-command credit limit. It also sequences kernel initialisation and keeps issue/ack accounting for host status readout.

## Interface
- `MAX_OUTSTANDING`, default 16: maximum issued-but-unacked commands; legal range 1..255.
- `CNT_W`, default 32: width of the issue and ack counters.

Ports:
- `I_CLK`, in, 1: single clock; all state changes on its rising edge.
- `I_RST`, in, 1: reset, synchronous, active-high.
- `I_INIT_REQ`, in, 1: pulse that requests kernel re-initialisation.
- `I_REQ_VALID`, in, 1: upstream request valid.
- `O_REQ_READY`, out, 1: upstream request ready.
- `I_REQ_OP`, in, 3: opcode. 0=ERASE, 1=WRITE, 2=READ, 3=SEARCH, 4=UPDATE; 5..7 are illegal.
- `I_REQ_KEY`, in, 128: key.
- `I_REQ_MSK`, in, 128: ekey mask.
- `I_REQ_PRI`, in, 7: priority.
- `I_REQ_VALUE`, in, 32: value.
- `I_KERNEL_READY`, in, 1: kernel ready status.
- `I_KERNEL_WAIT`, in, 1: kernel wait status.
- `I_KERNEL_CMD_FULL`, in, 1: kernel command queue full.
- `I_KERNEL_ACK`, in, 1: kernel ack, one pulse per completed command.
- `O_CMD_INIT`, out, 1: kernel init pulse.
- `O_CMD_VALID`, out, 1: command strobe to the kernel.
- `O_CMD_ERASE`, `O_CMD_WRITE`, `O_CMD_READ`, `O_CMD_SEARCH`, `O_CMD_UPDATE`, out, 1 each: one-hot command select.
- `O_KEY_DAT`, out, 128: key to the kernel.
- `O_EKEY_MSK`, out, 128: ekey mask to the kernel.
- `O_KEY_PRI`, out, 7: priority to the kernel.
- `O_KEY_VALUE`, out, 32: value to the kernel.
- `O_OUTSTANDING`, out, 8: current issued-minus-acked count.
- `O_ISSUED_CNT`, out, CNT_W: total commands issued.
- `O_ACK_CNT`, out, CNT_W: total acks received.
- `O_BUSY`, out, 1: high when state != RUN, or hold register valid, or outstanding != 0.
- `O_ERR`, out, 2: sticky error flags. bit0 = illegal opcode, bit1 = ack received with outstanding == 0.

## Operation
- **States.** The FSM has four states: WAIT_READY, RUN, DRAIN, INIT.
- **Reset.** Reset enters WAIT_READY.
- **WAIT_READY → RUN** when `I_KERNEL_READY` = 1.
- **RUN → DRAIN** on `I_INIT_REQ`. The request is latched if it arrives in any other state.
- **DRAIN → INIT** when the hold register is empty and outstanding == 0.
- **INIT.** Drives `O_CMD_INIT` = 1 for exactly one cycle, then → WAIT_READY.
- **Hold register.** One entry.
  - A request is accepted when `I_REQ_VALID` && `O_REQ_READY`.
  - `O_REQ_READY` = (state == RUN) && (!hold_valid || fire). It is combinational and does not depend on `I_REQ_VALID`.
- **Fire.** fire = hold_valid && `I_KERNEL_READY` && !`I_KERNEL_WAIT` && !`I_KERNEL_CMD_FULL` && outstanding < `MAX_OUTSTANDING`, in state RUN or DRAIN.
- **Command drive.** On fire:
  - Next cycle `O_CMD_VALID` = 1 for one cycle.
  - Exactly one opcode bit is set, decoded from the held op.
  - Key, mask, priority and value are registered from the hold register.
  - Data outputs keep their last value while `O_CMD_VALID` = 0; the select bits return to 0.
- **Illegal opcode.** Accepted, then dropped inside the hold register (never fired). Sets `O_ERR[0]`.
- **Outstanding counter.**
  - +1 on fire, −1 on `I_KERNEL_ACK`; unchanged when both occur in the same cycle.
  - An ack while outstanding == 0 with no fire sets `O_ERR[1]` and leaves the counter at 0.
- **Issue/ack counters.** Increment on fire and on ack respectively; they wrap modulo 2^CNT_W.
- **Kernel not ready.** If `I_KERNEL_READY` falls while in RUN, firing stalls but the state is unchanged.

## Timing
- **Reset values.**
  - `O_CMD_*` = 0, data outputs = 0.
  - Counters = 0, `O_ERR` = 0, `O_REQ_READY` = 0.
  - `O_BUSY` = 1 until RUN is reached with no pending work.
- **Latency.** Accept to `O_CMD_VALID` is 2 cycles minimum: hold register, then output register.
- **Throughput.** Back-to-back requests sustain 1 command per cycle.
- **Credit limit.** At outstanding == `MAX_OUTSTANDING` no fire occurs. An ack in that cycle frees credit for the next cycle, not the same cycle.
- **Reset mid-operation.** `I_RST` discards the hold register and outstanding state in that cycle.

## Structure
- **Package `axonerve_kvs_pkg`:**
  - `kvs_op_t` enum (3-bit).
  - `kvs_cmd_t` struct: op, key, msk, pri, value.
  - Constants `KVS_KEY_W` = 128, `KVS_VAL_W` = 32, `KVS_PRI_W` = 7.
- **Sub-module `axonerve_kvs_cmd_hold`:** the one-entry hold register with valid/ready plus the illegal-op drop.
- **Top level:** FSM, fire logic, output registers, counters.

## Test plan
- **Reset then ready.** Hold `I_RST` 5 cycles; assert `I_KERNEL_READY` at cycle 10 → `O_REQ_READY` rises the next cycle; all outputs 0 before that.
- **Write then search.** WRITE key `abadcafe…` value `34343434`, then SEARCH the same key on consecutive cycles:
  - `O_CMD_VALID` on two consecutive cycles with one-hot `01000` then `00010`.
  - Outstanding = 2; after two acks, outstanding = 0 and `O_ACK_CNT` = 2.
- **Credit limit.** `MAX_OUTSTANDING` = 4, 6 requests, no acks → exactly 4 fires and `O_REQ_READY` = 0. One ack → exactly one more fire.
- **Kernel backpressure.** Assert `I_KERNEL_CMD_FULL` (and separately `I_KERNEL_WAIT`) for 3 cycles → no `O_CMD_VALID` during those cycles; the held command issues after deassert with no data corruption.
- **Illegal opcode and spurious ack.** Op = 6 → no command issued and `O_ERR` = 01. A spurious ack at idle → `O_ERR` = 11.
- **Init with work pending.** `I_INIT_REQ` with 2 outstanding:
  - `O_CMD_INIT` pulses exactly once, only after both acks.
  - Then WAIT_READY → RUN on `I_KERNEL_READY`.

Source files
------------

// File: rtl/axonerve_kvs_pkg.sv
// Shared types and constants for the Axonerve KVS command path.
//   kvs_op_t      : 3-bit opcode (5..7 are illegal and never issued)
//   kvs_cmd_t     : one packed request (op, key, mask, priority, value)
//   iss_state_t   : command issuer FSM states
//   kvs_op_legal  : opcode legality check
//   kvs_op_onehot : opcode to {erase, write, read, search, update} select
package axonerve_kvs_pkg;

  localparam int unsigned KVS_KEY_W = 128;
  localparam int unsigned KVS_VAL_W = 32;
  localparam int unsigned KVS_PRI_W = 7;

  typedef enum logic [2:0] {
    OpErase  = 3'd0,
    OpWrite  = 3'd1,
    OpRead   = 3'd2,
    OpSearch = 3'd3,
    OpUpdate = 3'd4
  } kvs_op_t;

  typedef struct packed {
    kvs_op_t                op;
    logic [KVS_KEY_W-1:0]   key;
    logic [KVS_KEY_W-1:0]   msk;
    logic [KVS_PRI_W-1:0]   pri;
    logic [KVS_VAL_W-1:0]   value;
  } kvs_cmd_t;

  typedef enum logic [1:0] {
    StWaitReady = 2'd0,
    StRun       = 2'd1,
    StDrain     = 2'd2,
    StInit      = 2'd3
  } iss_state_t;

  function automatic logic kvs_op_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  // Bit order matches {ERASE, WRITE, READ, SEARCH, UPDATE}.
  function automatic logic [4:0] kvs_op_onehot(input kvs_op_t op);
    logic [4:0] sel;
    sel = 5'b00000;
    unique case (op)
      OpErase:  sel = 5'b10000;
      OpWrite:  sel = 5'b01000;
      OpRead:   sel = 5'b00100;
      OpSearch: sel = 5'b00010;
      OpUpdate: sel = 5'b00001;
      default:  sel = 5'b00000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/axonerve_kvs_cmd_hold.sv
// One-entry hold register between the upstream request stream and the issuer.
//   I_CLK, I_RST : clock, synchronous active-high reset
//   I_EN         : accepting allowed (issuer in RUN)
//   I_VALID/O_READY/I_CMD : upstream request handshake and payload
//   I_FIRE       : held command is issued this cycle (frees the entry)
//   O_VALID/O_CMD: held command
//   O_ILLEGAL    : pulse, an accepted request had an illegal opcode and was dropped
module axonerve_kvs_cmd_hold
  import axonerve_kvs_pkg::*;
(
  input  logic     I_CLK,
  input  logic     I_RST,
  input  logic     I_EN,
  input  logic     I_VALID,
  output logic     O_READY,
  input  kvs_cmd_t I_CMD,
  input  logic     I_FIRE,
  output logic     O_VALID,
  output kvs_cmd_t O_CMD,
  output logic     O_ILLEGAL
);

  logic     valid_q;
  kvs_cmd_t cmd_q;
  logic     accept;
  logic     legal;

  // Ready does not look at I_VALID; a firing entry can be replaced in the same cycle.
  assign O_READY   = I_EN && (!valid_q || I_FIRE);
  assign accept    = I_VALID && O_READY;
  assign legal     = kvs_op_legal(I_CMD.op);
  assign O_ILLEGAL = accept && !legal;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
    end else if (accept) begin
      // Illegal ops are taken off the stream but never become valid.
      valid_q <= legal;
      cmd_q   <= I_CMD;
    end else if (I_FIRE) begin
      valid_q <= 1'b0;
    end
  end

  assign O_VALID = valid_q;
  assign O_CMD   = cmd_q;

endmodule

// File: rtl/axonerve_kvs_cmd_issuer.sv
// Command issuer in front of axonerve_kvs_kernel.
//   I_CLK, I_RST          : clock, synchronous active-high reset
//   I_INIT_REQ            : request kernel re-initialisation (latched outside RUN)
//   I_REQ_*, O_REQ_READY  : upstream request stream
//   I_KERNEL_*            : kernel status and ack
//   O_CMD_*, O_KEY_*, O_EKEY_MSK : registered one-hot command interface to the kernel
//   O_OUTSTANDING, O_ISSUED_CNT, O_ACK_CNT, O_BUSY, O_ERR : status for host readout
module axonerve_kvs_cmd_issuer
  import axonerve_kvs_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_INIT_REQ,
  input  logic             I_REQ_VALID,
  output logic             O_REQ_READY,
  input  logic [2:0]       I_REQ_OP,
  input  logic [127:0]     I_REQ_KEY,
  input  logic [127:0]     I_REQ_MSK,
  input  logic [6:0]       I_REQ_PRI,
  input  logic [31:0]      I_REQ_VALUE,
  input  logic             I_KERNEL_READY,
  input  logic             I_KERNEL_WAIT,
  input  logic             I_KERNEL_CMD_FULL,
  input  logic             I_KERNEL_ACK,
  output logic             O_CMD_INIT,
  output logic             O_CMD_VALID,
  output logic             O_CMD_ERASE,
  output logic             O_CMD_WRITE,
  output logic             O_CMD_READ,
  output logic             O_CMD_SEARCH,
  output logic             O_CMD_UPDATE,
  output logic [127:0]     O_KEY_DAT,
  output logic [127:0]     O_EKEY_MSK,
  output logic [6:0]       O_KEY_PRI,
  output logic [31:0]      O_KEY_VALUE,
  output logic [7:0]       O_OUTSTANDING,
  output logic [CNT_W-1:0] O_ISSUED_CNT,
  output logic [CNT_W-1:0] O_ACK_CNT,
  output logic             O_BUSY,
  output logic [1:0]       O_ERR
);

  localparam logic [7:0] MaxOut = 8'(MAX_OUTSTANDING);

  iss_state_t       state_q;
  logic             init_pend_q;
  logic             cmd_init_q;
  logic             cmd_valid_q;
  logic [4:0]       cmd_sel_q;
  logic [127:0]     key_q;
  logic [127:0]     msk_q;
  logic [6:0]       pri_q;
  logic [31:0]      value_q;
  logic [7:0]       outstanding_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] ack_cnt_q;
  logic [1:0]       err_q;

  kvs_cmd_t req_cmd;
  kvs_cmd_t hold_cmd;
  logic     hold_valid;
  logic     illegal_drop;
  logic     fire;

  always_comb begin
    req_cmd       = '0;
    req_cmd.op    = kvs_op_t'(I_REQ_OP);
    req_cmd.key   = I_REQ_KEY;
    req_cmd.msk   = I_REQ_MSK;
    req_cmd.pri   = I_REQ_PRI;
    req_cmd.value = I_REQ_VALUE;
  end

  // Credit check uses the registered count, so an ack only frees credit next cycle.
  assign fire = hold_valid && I_KERNEL_READY && !I_KERNEL_WAIT && !I_KERNEL_CMD_FULL &&
                (outstanding_q < MaxOut) && ((state_q == StRun) || (state_q == StDrain));

  axonerve_kvs_cmd_hold u_hold (
    .I_CLK     (I_CLK),
    .I_RST     (I_RST),
    .I_EN      (state_q == StRun),
    .I_VALID   (I_REQ_VALID),
    .O_READY   (O_REQ_READY),
    .I_CMD     (req_cmd),
    .I_FIRE    (fire),
    .O_VALID   (hold_valid),
    .O_CMD     (hold_cmd),
    .O_ILLEGAL (illegal_drop)
  );

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q       <= StWaitReady;
      init_pend_q   <= 1'b0;
      cmd_init_q    <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_sel_q     <= 5'b00000;
      key_q         <= '0;
      msk_q         <= '0;
      pri_q         <= '0;
      value_q       <= '0;
      outstanding_q <= '0;
      issued_q      <= '0;
      ack_cnt_q     <= '0;
      err_q         <= 2'b00;
    end else begin
      cmd_init_q <= 1'b0;
      unique case (state_q)
        StWaitReady: if (I_KERNEL_READY) state_q <= StRun;
        StRun: begin
          init_pend_q <= 1'b0;
          if (I_INIT_REQ || init_pend_q) state_q <= StDrain;
        end
        StDrain: begin
          if (!hold_valid && (outstanding_q == 8'd0)) begin
            state_q    <= StInit;
            cmd_init_q <= 1'b1;
          end
        end
        StInit:  state_q <= StWaitReady;
        default: state_q <= StWaitReady;
      endcase
      // Init requests outside RUN are remembered until RUN is reached again.
      if ((state_q != StRun) && I_INIT_REQ) init_pend_q <= 1'b1;

      cmd_valid_q <= fire;
      cmd_sel_q   <= fire ? kvs_op_onehot(hold_cmd.op) : 5'b00000;
      if (fire) begin
        key_q   <= hold_cmd.key;
        msk_q   <= hold_cmd.msk;
        pri_q   <= hold_cmd.pri;
        value_q <= hold_cmd.value;
      end

      if (fire && !I_KERNEL_ACK) begin
        outstanding_q <= outstanding_q + 8'd1;
      end else if (I_KERNEL_ACK && !fire) begin
        if (outstanding_q == 8'd0) err_q[1] <= 1'b1;
        else                       outstanding_q <= outstanding_q - 8'd1;
      end

      if (fire)         issued_q  <= issued_q + 1'b1;
      if (I_KERNEL_ACK) ack_cnt_q <= ack_cnt_q + 1'b1;
      if (illegal_drop) err_q[0]  <= 1'b1;
    end
  end

  assign O_CMD_INIT    = cmd_init_q;
  assign O_CMD_VALID   = cmd_valid_q;
  assign O_CMD_ERASE   = cmd_sel_q[4];
  assign O_CMD_WRITE   = cmd_sel_q[3];
  assign O_CMD_READ    = cmd_sel_q[2];
  assign O_CMD_SEARCH  = cmd_sel_q[1];
  assign O_CMD_UPDATE  = cmd_sel_q[0];
  assign O_KEY_DAT     = key_q;
  assign O_EKEY_MSK    = msk_q;
  assign O_KEY_PRI     = pri_q;
  assign O_KEY_VALUE   = value_q;
  assign O_OUTSTANDING = outstanding_q;
  assign O_ISSUED_CNT  = issued_q;
  assign O_ACK_CNT     = ack_cnt_q;
  assign O_ERR         = err_q;
  assign O_BUSY        = (state_q != StRun) || hold_valid || (outstanding_q != 8'd0);

endmodule

// File: tb/tb_axonerve_kvs_cmd_issuer.sv
// Directed self-checking bench for axonerve_kvs_cmd_issuer (MAX_OUTSTANDING = 4).
module tb_axonerve_kvs_cmd_issuer;

  logic         I_CLK = 1'b0;
  logic         I_RST, I_INIT_REQ, I_REQ_VALID, O_REQ_READY;
  logic [2:0]   I_REQ_OP;
  logic [127:0] I_REQ_KEY, I_REQ_MSK;
  logic [6:0]   I_REQ_PRI;
  logic [31:0]  I_REQ_VALUE;
  logic         I_KERNEL_READY, I_KERNEL_WAIT, I_KERNEL_CMD_FULL, I_KERNEL_ACK;
  logic         O_CMD_INIT, O_CMD_VALID;
  logic         O_CMD_ERASE, O_CMD_WRITE, O_CMD_READ, O_CMD_SEARCH, O_CMD_UPDATE;
  logic [127:0] O_KEY_DAT, O_EKEY_MSK;
  logic [6:0]   O_KEY_PRI;
  logic [31:0]  O_KEY_VALUE;
  logic [7:0]   O_OUTSTANDING;
  logic [31:0]  O_ISSUED_CNT, O_ACK_CNT;
  logic         O_BUSY;
  logic [1:0]   O_ERR;

  int n_checks = 0;
  int n_errors = 0;
  int n_cmd    = 0;
  int n_init   = 0;
  int sent     = 0;
  int base;
  logic [4:0] sel;

  localparam logic [127:0] KeyA = 128'habadcafe_abadcafe_abadcafe_abadcafe;
  localparam logic [127:0] KeyB = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] KeyC = 128'hdeadbeef_00000000_11111111_22222222;

  axonerve_kvs_cmd_issuer #(
    .MAX_OUTSTANDING (4),
    .CNT_W           (32)
  ) dut (
    .I_CLK             (I_CLK),
    .I_RST             (I_RST),
    .I_INIT_REQ        (I_INIT_REQ),
    .I_REQ_VALID       (I_REQ_VALID),
    .O_REQ_READY       (O_REQ_READY),
    .I_REQ_OP          (I_REQ_OP),
    .I_REQ_KEY         (I_REQ_KEY),
    .I_REQ_MSK         (I_REQ_MSK),
    .I_REQ_PRI         (I_REQ_PRI),
    .I_REQ_VALUE       (I_REQ_VALUE),
    .I_KERNEL_READY    (I_KERNEL_READY),
    .I_KERNEL_WAIT     (I_KERNEL_WAIT),
    .I_KERNEL_CMD_FULL (I_KERNEL_CMD_FULL),
    .I_KERNEL_ACK      (I_KERNEL_ACK),
    .O_CMD_INIT        (O_CMD_INIT),
    .O_CMD_VALID       (O_CMD_VALID),
    .O_CMD_ERASE       (O_CMD_ERASE),
    .O_CMD_WRITE       (O_CMD_WRITE),
    .O_CMD_READ        (O_CMD_READ),
    .O_CMD_SEARCH      (O_CMD_SEARCH),
    .O_CMD_UPDATE      (O_CMD_UPDATE),
    .O_KEY_DAT         (O_KEY_DAT),
    .O_EKEY_MSK        (O_EKEY_MSK),
    .O_KEY_PRI         (O_KEY_PRI),
    .O_KEY_VALUE       (O_KEY_VALUE),
    .O_OUTSTANDING     (O_OUTSTANDING),
    .O_ISSUED_CNT      (O_ISSUED_CNT),
    .O_ACK_CNT         (O_ACK_CNT),
    .O_BUSY            (O_BUSY),
    .O_ERR             (O_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  assign sel = {O_CMD_ERASE, O_CMD_WRITE, O_CMD_READ, O_CMD_SEARCH, O_CMD_UPDATE};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic ack_pulse();
    I_KERNEL_ACK = 1'b1;
    cyc();
    I_KERNEL_ACK = 1'b0;
    cyc();
  endtask

  // Offers READ requests until `total` have been accepted, for `cycles` cycles.
  task automatic drive_reqs(input int total, input int cycles);
    I_REQ_OP = 3'd2;
    for (int i = 0; i < cycles; i++) begin
      I_REQ_VALID = (sent < total);
      I_REQ_KEY   = 128'(sent);
      @(negedge I_CLK);
      if (I_REQ_VALID && O_REQ_READY) sent++;
      @(posedge I_CLK);
      #1;
    end
    I_REQ_VALID = 1'b0;
  endtask

  // Mid-cycle monitor: count strobes and check select bits against the strobe.
  always @(negedge I_CLK) begin
    if (!I_RST) begin
      if (O_CMD_VALID) begin
        n_cmd++;
        check("sel_onehot", 128'($countones(sel)), 128'd1);
      end else begin
        check("sel_idle", 128'(sel), 128'd0);
      end
      if (O_CMD_INIT) n_init++;
    end
  end

  initial begin
    I_RST = 1'b1; I_INIT_REQ = 1'b0; I_REQ_VALID = 1'b0; I_REQ_OP = 3'd0;
    I_REQ_KEY = '0; I_REQ_MSK = '0; I_REQ_PRI = '0; I_REQ_VALUE = '0;
    I_KERNEL_READY = 1'b0; I_KERNEL_WAIT = 1'b0; I_KERNEL_CMD_FULL = 1'b0;
    I_KERNEL_ACK = 1'b0;

    // Reset then ready
    repeat (5) @(posedge I_CLK);
    #1 I_RST = 1'b0;
    check("rst_req_ready", 128'(O_REQ_READY), 128'd0);
    check("rst_cmd_valid", 128'(O_CMD_VALID), 128'd0);
    check("rst_key", O_KEY_DAT, 128'd0);
    check("rst_value", 128'(O_KEY_VALUE), 128'd0);
    check("rst_issued", 128'(O_ISSUED_CNT), 128'd0);
    check("rst_err", 128'(O_ERR), 128'd0);
    check("rst_busy", 128'(O_BUSY), 128'd1);
    repeat (4) cyc();
    check("wait_ready_req_ready", 128'(O_REQ_READY), 128'd0);
    I_KERNEL_READY = 1'b1;
    cyc();
    check("run_req_ready", 128'(O_REQ_READY), 128'd1);
    check("run_busy", 128'(O_BUSY), 128'd0);

    // Write then search, back to back
    I_REQ_VALID = 1'b1; I_REQ_OP = 3'd1; I_REQ_KEY = KeyA;
    I_REQ_MSK = 128'hff; I_REQ_PRI = 7'h12; I_REQ_VALUE = 32'h34343434;
    cyc();
    I_REQ_OP = 3'd3; I_REQ_VALUE = 32'h56565656;
    cyc();
    check("wr_valid", 128'(O_CMD_VALID), 128'd1);
    check("wr_sel", 128'(sel), 128'b01000);
    check("wr_key", O_KEY_DAT, KeyA);
    check("wr_msk", O_EKEY_MSK, 128'hff);
    check("wr_pri", 128'(O_KEY_PRI), 128'h12);
    check("wr_value", 128'(O_KEY_VALUE), 128'h34343434);
    I_REQ_VALID = 1'b0;
    cyc();
    check("sr_valid", 128'(O_CMD_VALID), 128'd1);
    check("sr_sel", 128'(sel), 128'b00010);
    check("sr_value", 128'(O_KEY_VALUE), 128'h56565656);
    cyc();
    check("idle_valid", 128'(O_CMD_VALID), 128'd0);
    check("idle_value_held", 128'(O_KEY_VALUE), 128'h56565656);
    check("idle_key_held", O_KEY_DAT, KeyA);
    check("ws_outstanding", 128'(O_OUTSTANDING), 128'd2);
    check("ws_issued", 128'(O_ISSUED_CNT), 128'd2);
    I_KERNEL_ACK = 1'b1;
    cyc();
    cyc();
    I_KERNEL_ACK = 1'b0;
    check("ws_outstanding_acked", 128'(O_OUTSTANDING), 128'd0);
    check("ws_ack_cnt", 128'(O_ACK_CNT), 128'd2);

    // Credit limit: 4 fire, 5th held, 6th refused
    base = n_cmd; sent = 0;
    drive_reqs(6, 12);
    check("credit_fires", 128'(n_cmd - base), 128'd4);
    check("credit_accepts", 128'(sent), 128'd5);
    check("credit_req_ready", 128'(O_REQ_READY), 128'd0);
    check("credit_outstanding", 128'(O_OUTSTANDING), 128'd4);
    I_KERNEL_ACK = 1'b1;
    cyc();
    I_KERNEL_ACK = 1'b0;
    drive_reqs(6, 6);
    check("credit_one_more", 128'(n_cmd - base), 128'd5);
    check("credit_accept_6", 128'(sent), 128'd6);
    check("credit_outstanding2", 128'(O_OUTSTANDING), 128'd4);
    ack_pulse();
    repeat (2) cyc();
    check("credit_sixth", 128'(n_cmd - base), 128'd6);
    repeat (4) ack_pulse();
    check("credit_drained", 128'(O_OUTSTANDING), 128'd0);
    check("credit_issued", 128'(O_ISSUED_CNT), 128'd8);
    check("credit_acks", 128'(O_ACK_CNT), 128'd8);

    // Backpressure: CMD_FULL then WAIT, 3 cycles each
    for (int k = 0; k < 2; k++) begin
      base = n_cmd;
      if (k == 0) I_KERNEL_CMD_FULL = 1'b1;
      else        I_KERNEL_WAIT = 1'b1;
      I_REQ_VALID = 1'b1;
      I_REQ_OP    = (k == 0) ? 3'd4 : 3'd0;
      I_REQ_KEY   = (k == 0) ? KeyB : KeyC;
      I_REQ_MSK   = (k == 0) ? 128'h0f0f : 128'hf0f0;
      I_REQ_PRI   = (k == 0) ? 7'h55 : 7'h2a;
      I_REQ_VALUE = (k == 0) ? 32'hcafef00d : 32'h0badf00d;
      cyc();
      I_REQ_VALID = 1'b0;
      I_REQ_KEY = '0; I_REQ_VALUE = '0; I_REQ_MSK = '0; I_REQ_PRI = '0;
      for (int j = 0; j < 3; j++) begin
        check("bp_stall", 128'(O_CMD_VALID), 128'd0);
        cyc();
      end
      I_KERNEL_CMD_FULL = 1'b0;
      I_KERNEL_WAIT = 1'b0;
      cyc();
      check("bp_valid", 128'(O_CMD_VALID), 128'd1);
      check("bp_sel", 128'(sel), (k == 0) ? 128'b00001 : 128'b10000);
      check("bp_key", O_KEY_DAT, (k == 0) ? KeyB : KeyC);
      check("bp_msk", O_EKEY_MSK, (k == 0) ? 128'h0f0f : 128'hf0f0);
      check("bp_pri", 128'(O_KEY_PRI), (k == 0) ? 128'h55 : 128'h2a);
      check("bp_value", 128'(O_KEY_VALUE), (k == 0) ? 128'hcafef00d : 128'h0badf00d);
      cyc();
      check("bp_count", 128'(n_cmd - base), 128'd1);
      ack_pulse();
    end

    // Illegal opcode, then spurious ack
    base = n_cmd;
    I_REQ_VALID = 1'b1; I_REQ_OP = 3'd6; I_REQ_KEY = KeyA;
    cyc();
    I_REQ_VALID = 1'b0;
    repeat (3) cyc();
    check("illegal_no_cmd", 128'(n_cmd - base), 128'd0);
    check("illegal_err", 128'(O_ERR), 128'b01);
    check("illegal_busy", 128'(O_BUSY), 128'd0);
    ack_pulse();
    check("spurious_err", 128'(O_ERR), 128'b11);
    check("spurious_outstanding", 128'(O_OUTSTANDING), 128'd0);

    // Init with two commands outstanding
    I_REQ_VALID = 1'b1; I_REQ_OP = 3'd1; I_REQ_KEY = KeyB;
    cyc();
    cyc();
    I_REQ_VALID = 1'b0;
    repeat (2) cyc();
    check("init_outstanding", 128'(O_OUTSTANDING), 128'd2);
    I_INIT_REQ = 1'b1;
    cyc();
    I_INIT_REQ = 1'b0;
    repeat (3) cyc();
    check("init_not_yet", 128'(n_init), 128'd0);
    check("drain_req_ready", 128'(O_REQ_READY), 128'd0);
    check("drain_busy", 128'(O_BUSY), 128'd1);
    ack_pulse();
    check("init_after_one_ack", 128'(n_init), 128'd0);
    I_KERNEL_READY = 1'b0;
    ack_pulse();
    for (int i = 0; i < 10 && n_init == 0; i++) cyc();
    check("init_pulse", 128'(n_init), 128'd1);
    repeat (3) cyc();
    check("init_once", 128'(n_init), 128'd1);
    check("post_init_wait", 128'(O_REQ_READY), 128'd0);
    I_KERNEL_READY = 1'b1;
    cyc();
    check("post_init_run", 128'(O_REQ_READY), 128'd1);
    check("post_init_busy", 128'(O_BUSY), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
